// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the fetch PC and issues one request at a
// time on a variable-latency instruction bus. It applies redirects in priority
// order exception > eret > branch. Fetched words go into a one-entry output
// slot that decode drains. Responses that become stale after a redirect are
// discarded.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   stall_d                      decode cannot accept the slot this cycle
//   br_taken/br_target           branch redirect
//   exc_req                      exception entry (target HANDLER_PC)
//   eret/epc                     eret redirect
//   ibus_req/ibus_addr           bus request (combinational; addr always = pc)
//   ibus_gnt                     request accepted
//   ibus_rvalid/ibus_rdata       bus response
//   f_valid/f_pc/f_instr/f_adel  output slot
//   busy                         a request is outstanding (state != ISSUE)
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI    = 32'h0000_4FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_d,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_gnt,
    input  logic        ibus_rvalid,
    input  logic [31:0] ibus_rdata,
    output logic        f_valid,
    output logic [31:0] f_pc,
    output logic [31:0] f_instr,
    output logic        f_adel,
    output logic        busy
);

    localparam logic [1:0] ST_ISSUE = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    logic [1:0]  state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_pc, req_pc_nxt;
    logic        f_valid_nxt, f_adel_nxt;
    logic [31:0] f_pc_nxt, f_instr_nxt;
    logic        req_c;

    logic        redirect, consume, slot_free, bad;
    logic [31:0] target;
    logic [31:0] pc_inc;

    // Redirect target selection and slot handshake terms
    assign redirect  = exc_req | eret | br_taken;
    assign target    = exc_req ? HANDLER_PC : (eret ? epc : br_target);
    assign consume   = f_valid & ~stall_d;
    assign slot_free = ~f_valid | consume;
    assign bad       = (pc[1:0] != 2'b00) | (pc < TEXT_LO) | (pc > TEXT_HI);
    assign pc_inc    = pc + 32'd4;

    // The request is qualified combinationally so a grant can land the same
    // cycle the slot is consumed.
    assign ibus_req  = req_c & ~reset;
    assign ibus_addr = pc;
    assign busy      = (state != ST_ISSUE);

    // Next-state and datapath decode
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        req_pc_nxt  = req_pc;
        f_valid_nxt = f_valid & ~consume;
        f_pc_nxt    = f_pc;
        f_instr_nxt = f_instr;
        f_adel_nxt  = f_adel;
        req_c       = 1'b0;

        case (state)
            ST_ISSUE: begin
                if (redirect) begin
                    state_nxt = ST_ISSUE;
                end else if (bad && slot_free) begin
                    // Illegal PC: emit an address-error marker instead of fetching
                    f_valid_nxt = 1'b1;
                    f_pc_nxt    = pc;
                    f_instr_nxt = 32'd0;
                    f_adel_nxt  = 1'b1;
                    pc_nxt      = pc_inc;
                end else if (slot_free) begin
                    req_c = 1'b1;
                    if (ibus_gnt) begin
                        req_pc_nxt = pc;
                        pc_nxt     = pc_inc;
                        state_nxt  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    // A same-cycle response is stale; otherwise wait it out in DROP
                    state_nxt = ibus_rvalid ? ST_ISSUE : ST_DROP;
                end else if (ibus_rvalid) begin
                    f_valid_nxt = 1'b1;
                    f_pc_nxt    = req_pc;
                    f_instr_nxt = ibus_rdata;
                    f_adel_nxt  = 1'b0;
                    state_nxt   = ST_ISSUE;
                end
            end
            ST_DROP: begin
                if (ibus_rvalid) begin
                    state_nxt = ST_ISSUE;
                end
            end
            default: begin
                state_nxt = ST_ISSUE;
            end
        endcase

        // Any redirect retargets the PC and flushes the slot, in every state
        if (redirect) begin
            pc_nxt      = target;
            f_valid_nxt = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_ISSUE;
            pc      <= RESET_PC;
            req_pc  <= 32'd0;
            f_valid <= 1'b0;
            f_pc    <= 32'd0;
            f_instr <= 32'd0;
            f_adel  <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            req_pc  <= req_pc_nxt;
            f_valid <= f_valid_nxt;
            f_pc    <= f_pc_nxt;
            f_instr <= f_instr_nxt;
            f_adel  <= f_adel_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: linear stimulus with hand-computed
// expectations checked by immediate assertions.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_d;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_adel;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fetch_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .stall_d    (stall_d),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .exc_req    (exc_req),
        .eret       (eret),
        .epc        (epc),
        .ibus_req   (ibus_req),
        .ibus_addr  (ibus_addr),
        .ibus_gnt   (ibus_gnt),
        .ibus_rvalid(ibus_rvalid),
        .ibus_rdata (ibus_rdata),
        .f_valid    (f_valid),
        .f_pc       (f_pc),
        .f_instr    (f_instr),
        .f_adel     (f_adel),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1; stall_d = 1'b0; br_taken = 1'b0; br_target = 32'd0;
        exc_req = 1'b0; eret = 1'b0; epc = 32'd0;
        ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = 32'd0;
        tick();
        tick();

        // Reset state (reset still asserted)
        chk("rst_req",     32'(ibus_req), 32'd0);
        chk("rst_addr",    ibus_addr,     32'h0000_3000);
        chk("rst_busy",    32'(busy),     32'd0);
        chk("rst_fvalid",  32'(f_valid),  32'd0);
        chk("rst_fpc",     f_pc,          32'd0);
        chk("rst_finstr",  f_instr,       32'd0);
        chk("rst_fadel",   32'(f_adel),   32'd0);

        // First fetch at 0x3000 over a 1-cycle bus
        reset = 1'b0; #1;
        chk("f1_req",  32'(ibus_req), 32'd1);
        chk("f1_addr", ibus_addr,     32'h0000_3000);
        ibus_gnt = 1'b1;
        tick();
        ibus_gnt = 1'b0; #1;
        chk("f1_wait_busy", 32'(busy),     32'd1);
        chk("f1_wait_req",  32'(ibus_req), 32'd0);
        chk("f1_wait_fv",   32'(f_valid),  32'd0);
        ibus_rvalid = 1'b1; ibus_rdata = 32'h2400_0001;
        tick();
        ibus_rvalid = 1'b0;

        // Slot full, decode stalled for 3 cycles
        stall_d = 1'b1; #1;
        chk("f1_fv",    32'(f_valid),  32'd1);
        chk("f1_fpc",   f_pc,          32'h0000_3000);
        chk("f1_instr", f_instr,       32'h2400_0001);
        chk("f1_adel",  32'(f_adel),   32'd0);
        chk("f1_busy",  32'(busy),     32'd0);
        chk("stall_req0", 32'(ibus_req), 32'd0);
        chk("next_addr",  ibus_addr,     32'h0000_3004);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_req",   32'(ibus_req), 32'd0);
            chk("stall_fv",    32'(f_valid),  32'd1);
            chk("stall_instr", f_instr,       32'h2400_0001);
        end
        tick();

        // Stall released: consume and issue to 0x3004 in the same cycle
        stall_d = 1'b0; #1;
        chk("cons_req",  32'(ibus_req), 32'd1);
        chk("cons_addr", ibus_addr,     32'h0000_3004);
        ibus_gnt = 1'b1;
        tick();
        ibus_gnt = 1'b0; #1;
        chk("cons_fv",   32'(f_valid), 32'd0);
        chk("cons_busy", 32'(busy),    32'd1);

        // Branch while waiting: response arriving later is dropped
        br_taken = 1'b1; br_target = 32'h0000_3100;
        tick();
        br_taken = 1'b0; #1;
        chk("drop_busy", 32'(busy),     32'd1);
        chk("drop_req",  32'(ibus_req), 32'd0);
        chk("drop_addr", ibus_addr,     32'h0000_3100);
        ibus_rvalid = 1'b1; ibus_rdata = 32'hDEAD_BEEF;
        tick();
        ibus_rvalid = 1'b0; #1;
        chk("drop_fv",    32'(f_valid),  32'd0);
        chk("drop_idle",  32'(busy),     32'd0);
        chk("br_req",     32'(ibus_req), 32'd1);
        chk("br_addr",    ibus_addr,     32'h0000_3100);
        ibus_gnt = 1'b1;
        tick();
        ibus_gnt = 1'b0;
        ibus_rvalid = 1'b1; ibus_rdata = 32'h8C00_0000;
        tick();
        ibus_rvalid = 1'b0;

        // All three redirects at once with a full, stalled slot
        stall_d = 1'b1; #1;
        chk("br_fv",  32'(f_valid), 32'd1);
        chk("br_fpc", f_pc,         32'h0000_3100);
        exc_req = 1'b1; eret = 1'b1; epc = 32'h0000_3020;
        br_taken = 1'b1; br_target = 32'h0000_3100; #1;
        chk("redir_req", 32'(ibus_req), 32'd0);
        tick();
        exc_req = 1'b0; eret = 1'b0; br_taken = 1'b0; stall_d = 1'b0; #1;
        chk("exc_fv",   32'(f_valid),  32'd0);
        chk("exc_addr", ibus_addr,     32'h0000_4180);
        chk("exc_req1", 32'(ibus_req), 32'd1);

        // eret to a misaligned PC yields an address-error slot
        eret = 1'b1; epc = 32'h0000_3002; #1;
        chk("eret_req", 32'(ibus_req), 32'd0);
        tick();
        eret = 1'b0; #1;
        chk("mis_addr", ibus_addr,     32'h0000_3002);
        chk("mis_req",  32'(ibus_req), 32'd0);
        chk("mis_fv0",  32'(f_valid),  32'd0);
        tick();
        chk("mis_fv",    32'(f_valid), 32'd1);
        chk("mis_adel",  32'(f_adel),  32'd1);
        chk("mis_fpc",   f_pc,         32'h0000_3002);
        chk("mis_instr", f_instr,      32'd0);

        // eret above the text range
        eret = 1'b1; epc = 32'h0000_5000;
        tick();
        eret = 1'b0; #1;
        chk("hi_fv0",  32'(f_valid),  32'd0);
        chk("hi_addr", ibus_addr,     32'h0000_5000);
        chk("hi_req",  32'(ibus_req), 32'd0);
        tick();
        chk("hi_fv",    32'(f_valid), 32'd1);
        chk("hi_adel",  32'(f_adel),  32'd1);
        chk("hi_fpc",   f_pc,         32'h0000_5000);
        chk("hi_instr", f_instr,      32'd0);

        // Last legal word of the text range fetches normally
        br_taken = 1'b1; br_target = 32'h0000_4FFC;
        tick();
        br_taken = 1'b0; #1;
        chk("top_fv",   32'(f_valid),  32'd0);
        chk("top_req",  32'(ibus_req), 32'd1);
        chk("top_addr", ibus_addr,     32'h0000_4FFC);
        ibus_gnt = 1'b1;
        tick();
        ibus_gnt = 1'b0; #1;
        chk("top_busy", 32'(busy), 32'd1);

        // Reset in WAIT returns to a fresh fetch at RESET_PC
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        chk("wrst_busy", 32'(busy),     32'd0);
        chk("wrst_fv",   32'(f_valid),  32'd0);
        chk("wrst_req",  32'(ibus_req), 32'd1);
        chk("wrst_addr", ibus_addr,     32'h0000_3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Sequences the instruction-fetch stage over a variable-latency instruction bus. It owns the fetch PC and issues one bus request at a time. It applies redirects in priority order: exception entry, eret, then branch. It presents fetched instructions in a one-entry output slot that decode drains, and it drops stale bus responses after a redirect.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset
HANDLER_PC, 32'h0000_4180, exception entry target
TEXT_LO, 32'h0000_3000, lowest legal fetch address
TEXT_HI, 32'h0000_4FFF, highest legal fetch address

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
stall_d  in  1  decode cannot accept the slot this cycle
br_taken  in  1  branch/jump redirect (single-cycle pulse)
br_target  in  32  branch target
exc_req  in  1  exception/interrupt entry request from CP0
eret  in  1  eret redirect
epc  in  32  eret target
ibus_req  out  1  request valid
ibus_addr  out  32  request address
ibus_gnt  in  1  request accepted this cycle (sampled only while ibus_req=1)
ibus_rvalid  in  1  response valid
ibus_rdata  in  32  response data
f_valid  out  1  slot holds an instruction
f_pc  out  32  PC of slot instruction
f_instr  out  32  slot instruction
f_adel  out  1  slot is an address-error fetch
busy  out  1  a bus request is outstanding (state != ISSUE)

Behaviour:
- Reset (synchronous, wins over everything): pc=RESET_PC, state=ISSUE, f_valid=0, f_pc=0, f_instr=0, f_adel=0, ibus_req=0. No outstanding request survives reset; the bus is reset by the same reset.
- redirect = exc_req|eret|br_taken. Target priority: exc_req→HANDLER_PC, else eret→epc, else br_target.
- Any redirect clears f_valid in the same edge and loads pc with the target.
- consume = f_valid & !stall_d. slot_free = !f_valid | consume.
- bad = pc[1:0]!=0 | pc<TEXT_LO | pc>TEXT_HI (unsigned compare).
- State ISSUE, priority as listed:
  - On redirect: ibus_req=0 and the state stays ISSUE.
  - Else if bad & slot_free: no bus request. Slot loads f_valid=1, f_pc=pc, f_instr=0, f_adel=1, and pc<=pc+4.
  - Else if slot_free: ibus_req=1, ibus_addr=pc.
    - On ibus_gnt: req_pc<=pc, pc<=pc+4, go to WAIT. If consume is also set this cycle, f_valid<=0.
  - Else: ibus_req=0 and the state holds.
- State WAIT: ibus_req=0; the slot is empty here.
  - On redirect with ibus_rvalid in the same cycle: drop the response, go to ISSUE.
  - On redirect without ibus_rvalid: go to DROP.
  - Else on ibus_rvalid: slot loads f_valid=1, f_pc=req_pc, f_instr=ibus_rdata, f_adel=0. Go to ISSUE.
- State DROP: ibus_req=0. A redirect updates pc only. On ibus_rvalid: discard the response, go to ISSUE.
- A slot consumed with no new load clears f_valid at the edge. The slot holds its value while stall_d=1.
- Latency: gnt in cycle N, rvalid earliest N+1, f_valid=1 from N+2. Back-to-back with no stall and 1-cycle bus: one instruction every 2 cycles.
- pc+4 wraps modulo 2^32.
- ibus_addr=pc at all times; only ibus_req qualifies it.

Test Plan:
- Reset then 1-cycle-latency bus returning 0x2400_0001 at 0x3000 → ibus_req/addr=0x3000 on the first cycle. f_valid=1, f_pc=0x3000, f_instr=0x2400_0001 two cycles after gnt. The next request goes to 0x3004.
- Hold stall_d=1 for 3 cycles with the slot full → no ibus_req. The slot stays unchanged. After stall_d drops, a request to the next PC issues in the same cycle as consume.
- Pulse br_taken (target 0x3100) while in WAIT, with the response 2 cycles later → slot stays empty and the response is dropped (DROP→ISSUE). The next request goes to 0x3100.
- Assert exc_req, eret (epc=0x3020) and br_taken in the same cycle → pc=0x4180 and f_valid=0.
- Pulse eret with epc=0x3002 → no bus request. The slot shows f_adel=1, f_pc=0x3002, f_instr=0. Repeat with epc=0x5000 → same result.
- Assert reset while in WAIT → next cycle pc=0x3000, state ISSUE, f_valid=0, and ibus_req=1 to 0x3000.
